// File: rtl/hash_result_reader.sv
// hash_result_reader: reads NUM_NONCES H0 result words back from the hash
// core's single-port word memory, compares each against a difficulty target,
// streams one result beat per word over a valid/ready port and tracks the hit
// count plus the lowest hash and its nonce.
// Optional build macro HASH_READER_FILTER_EN: when defined, only hit words are
// streamed (non-hits skip the beat); counters and best tracking still see
// every word.
module hash_result_reader #(
  parameter int NUM_NONCES = 16,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      output_addr,
  input  logic [31:0]      target,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_nonce,
  output logic [31:0]      res_hash,
  output logic             res_hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [31:0]      best_nonce,
  output logic [31:0]      best_hash
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q;
  logic [15:0]      base_q;
  logic [31:0]      target_q;
  logic [31:0]      idx_q;
  logic [15:0]      mem_addr_q;
  logic             res_valid_q;
  logic [31:0]      res_nonce_q;
  logic [31:0]      res_hash_q;
  logic             res_hit_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] hit_count_q;
  logic [31:0]      best_nonce_q;
  logic [31:0]      best_hash_q;

  // Next word index and its memory address (16-bit wrap is intentional).
  logic [31:0] idx_d;
  logic [15:0] mem_addr_d;
  logic        hit_s;
  logic        better_s;
  logic        last_s;
  logic        start_fire_s;

  assign idx_d        = idx_q + 32'd1;
  assign mem_addr_d   = base_q + idx_d[15:0];
  assign hit_s        = (mem_read_data < target_q);
  // Strict compare: on a tie the earlier (lower) nonce is kept.
  assign better_s     = (mem_read_data < best_hash_q);
  assign last_s       = (idx_q == 32'(NUM_NONCES - 1));
  // start is only honoured when no pass is in flight.
  assign start_fire_s = start && ((state_q == S_IDLE) || (state_q == S_FINISH));

  // Read-back sequencer: walks ADDR -> WAIT -> EMIT per word, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= 16'd0;
      target_q     <= 32'd0;
      idx_q        <= 32'd0;
      mem_addr_q   <= 16'd0;
      res_valid_q  <= 1'b0;
      res_nonce_q  <= 32'd0;
      res_hash_q   <= 32'd0;
      res_hit_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_count_q  <= '0;
      best_nonce_q <= 32'd0;
      best_hash_q  <= 32'hFFFF_FFFF;
    end else if (start_fire_s) begin
      base_q       <= output_addr;
      target_q     <= target;
      idx_q        <= 32'd0;
      mem_addr_q   <= output_addr;
      hit_count_q  <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_nonce_q <= 32'd0;
      state_q      <= S_ADDR;
    end else begin
      case (state_q)
        S_ADDR: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          res_hash_q  <= mem_read_data;
          res_nonce_q <= idx_q;
          res_hit_q   <= hit_s;
          if (hit_s) begin
            hit_count_q <= hit_count_q + CNT_W'(1);
          end else begin
            hit_count_q <= hit_count_q;
          end
          if (better_s) begin
            best_hash_q  <= mem_read_data;
            best_nonce_q <= idx_q;
          end else begin
            best_hash_q  <= best_hash_q;
          end
`ifdef HASH_READER_FILTER_EN
          if (hit_s) begin
            res_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else if (last_s) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            idx_q      <= idx_d;
            mem_addr_q <= mem_addr_d;
            state_q    <= S_ADDR;
          end
`else
          res_valid_q <= 1'b1;
          state_q     <= S_EMIT;
`endif
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (last_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              idx_q      <= idx_d;
              mem_addr_q <= mem_addr_d;
              state_q    <= S_ADDR;
            end
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        S_FINISH: begin
          state_q <= S_FINISH;
        end
        default: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;
  assign mem_addr       = mem_addr_q;
  assign res_valid      = res_valid_q;
  assign res_nonce      = res_nonce_q;
  assign res_hash       = res_hash_q;
  assign res_hit        = res_hit_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign hit_count      = hit_count_q;
  assign best_nonce     = best_nonce_q;
  assign best_hash      = best_hash_q;

endmodule

// File: tb/tb_hash_result_reader.sv
// Scoreboard bench for hash_result_reader: a reference model computes the
// expected beats and pass summary from memory contents; a monitor process
// pops and compares every handshaken beat.
module tb_hash_result_reader;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, start, res_ready;
  logic [15:0] output_addr;
  logic [31:0] target;
  logic        mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        res_valid, res_hit, busy, done;
  logic [31:0] res_nonce, res_hash, best_nonce, best_hash;
  logic [5:0]  hit_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:65535];

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] hash;
    logic        hit;
  } beat_t;
  beat_t       exp_q[$];
  logic [15:0] addr_log[$];

  int rmode = 0;        // 0: ready high, 1: random, 2: stall one nonce
  int stall_nonce = 0;
  int stall_len = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  hash_result_reader #(.NUM_NONCES(N), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .target(target),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_hash(res_hash), .res_hit(res_hit), .busy(busy), .done(done),
    .hit_count(hit_count), .best_nonce(best_nonce), .best_hash(best_hash)
  );

  // synchronous-read memory: data for an address appears the cycle after
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // downstream ready generator
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (res_valid && res_nonce == 32'(stall_nonce) && stall_cnt < stall_len) begin
            res_ready = 1'b0;
            stall_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // monitor: scoreboard pops, hold-stability while stalled, address log, mem_we
  initial begin
    bit          stalled = 1'b0;
    logic [31:0] sv_nonce = 32'd0, sv_hash = 32'd0;
    logic        sv_hit = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        chk("mem_we", {31'd0, mem_we}, 32'd0);
        if (stalled) begin
          chk("hold_valid", {31'd0, res_valid}, 32'd1);
          chk("hold_nonce", res_nonce, sv_nonce);
          chk("hold_hash", res_hash, sv_hash);
          chk("hold_hit", {31'd0, res_hit}, {31'd0, sv_hit});
        end
        if (busy && (addr_log.size() == 0 || addr_log[$] != mem_addr))
          addr_log.push_back(mem_addr);
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got nonce %0d expected no beat", res_nonce);
          end else begin
            e = exp_q.pop_front();
            chk("beat_nonce", res_nonce, e.nonce);
            chk("beat_hash", res_hash, e.hash);
            chk("beat_hit", {31'd0, res_hit}, {31'd0, e.hit});
          end
        end
        stalled  = res_valid && !res_ready;
        sv_nonce = res_nonce;
        sv_hash  = res_hash;
        sv_hit   = res_hit;
      end
    end
  end

  // reference model: expected beats pushed to scoreboard, summary returned
  task automatic model(input logic [15:0] base, input logic [31:0] tgt,
                       output int cnt, output int bn, output logic [31:0] best,
                       output int cyc);
    logic [31:0] h;
    logic        hit;
    cnt = 0; bn = 0; best = 32'hFFFF_FFFF; cyc = 0;
    for (int n = 0; n < N; n++) begin
      h   = mem[base + 16'(n)];
      hit = (h < tgt);
      if (hit) cnt++;
      if (h < best) begin best = h; bn = n; end
`ifdef HASH_READER_FILTER_EN
      if (hit) exp_q.push_back('{32'(n), h, hit});
      cyc += hit ? 3 : 2;
`else
      exp_q.push_back('{32'(n), h, hit});
      cyc += 3;
`endif
    end
  endtask

  task automatic run_pass(input logic [15:0] base, input logic [31:0] tgt, input bit extra_start);
    int cnt, bn, exp_cyc, cyc;
    logic [31:0] best;
    bit ok;
    model(base, tgt, cnt, bn, best, exp_cyc);
    addr_log.delete();
    stall_cnt = 0;
    cyc = 0;
    output_addr = base; target = tgt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    output_addr = ~base; target = ~tgt;   // latched copies must be used
    while (!done && cyc < 2000) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) chk("busy_running", {31'd0, busy}, 32'd1);
      start = extra_start && (cyc == 10);
    end
    start = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    if (rmode == 0) chk("pass_cycles", 32'(cyc), 32'(exp_cyc));
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("hit_count", {26'd0, hit_count}, 32'(cnt));
    chk("best_hash", best_hash, best);
    chk("best_nonce", best_nonce, 32'(bn));
    ok = (addr_log.size() == N);
    for (int n = 0; n < N && ok; n++)
      if (addr_log[n] != base + 16'(n)) ok = 1'b0;
    chk("addr_seq", {31'd0, ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, bn, cyc, waited;
    logic [31:0] best;
    reset = 1'b1; start = 1'b0; output_addr = 16'd0; target = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hits", {26'd0, hit_count}, 32'd0);
    chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    chk("rst_best_nonce", best_nonce, 32'd0);
    chk("rst_nonce", res_nonce, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    // descending words 16-n, target 5
    for (int n = 0; n < N; n++) mem[16'h0100 + 16'(n)] = 32'(16 - n);
    rmode = 0;
    run_pass(16'h0100, 32'd5, 1'b0);
    // same with nonce 3 stalled for 10 cycles
    rmode = 2; stall_nonce = 3; stall_len = 10;
    run_pass(16'h0100, 32'd5, 1'b0);
    // all equal words: tie keeps nonce 0
    for (int n = 0; n < N; n++) mem[16'h0200 + 16'(n)] = 32'd7;
    rmode = 1;
    run_pass(16'h0200, 32'd8, 1'b0);
    // address wrap
    for (int n = 0; n < N; n++) mem[16'hFFF8 + 16'(n)] = $urandom;
    run_pass(16'hFFF8, 32'h8000_0000, 1'b0);

    // reset while a beat for nonce 6 is pending
    for (int n = 0; n < N; n++) mem[16'h0300 + 16'(n)] = 32'd0;
    rmode = 2; stall_nonce = 6; stall_len = 1000; stall_cnt = 0;
    model(16'h0300, 32'd1, cnt, bn, best, cyc);
    output_addr = 16'h0300; target = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(res_valid && res_nonce == 32'd6 && stall_cnt >= 3) && waited < 500) begin
      @(posedge clk); #1; waited++;
    end
    chk("reach_nonce6", {31'd0, (waited < 500)}, 32'd1);
    chk("pending_beats", 32'(exp_q.size()), 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hits", {26'd0, hit_count}, 32'd0);
    chk("abort_best", best_hash, 32'hFFFF_FFFF);
    chk("abort_done", {31'd0, done}, 32'd0);
    rmode = 0;
    run_pass(16'h0100, 32'd5, 1'b1);   // also: start during busy ignored

    // target extremes
    for (int n = 0; n < N; n++)
      mem[16'h0400 + 16'(n)] = (n % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
    run_pass(16'h0400, 32'd0, 1'b0);
    rmode = 1;
    run_pass(16'h0400, 32'hFFFF_FFFF, 1'b1);

    // random passes
    for (int p = 0; p < 4; p++) begin
      logic [15:0] b;
      b = 16'($urandom);
      for (int n = 0; n < N; n++) mem[b + 16'(n)] = 32'($urandom_range(0, 64));
      rmode = p % 2;
      run_pass(b, 32'($urandom_range(0, 64)), 1'(p % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
